mbc_bus_arb: RTL



---
 rtl/mbc_pkg.sv | 25 ++
 rtl/mbc_rr_pick.sv | 39 +++
 rtl/mbc_bus_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mbc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mbc_pkg - shared bus widths, busy bit position and arbiter FSM state type.
// Revision: 1.0
// ---------------------------------------------------------------------------
package mbc_pkg;

    localparam int MBC_ADDR_W        = 32;
    localparam int MBC_DATA_W        = 32;
    localparam int MBC_CTRL_BUSY_BIT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mbc_state_t;

    // A request must name exactly one direction to be issued on the bus.
    function automatic logic mbc_req_legal(input logic wr, input logic rd);
        return wr ^ rd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mbc_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mbc_rr_pick - combinational round-robin winner select starting at last+1.
// Optional MBC_ARB_PRIORITY_EN makes requester 0 fixed highest priority. Rev 1.0
// ---------------------------------------------------------------------------
module mbc_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    logic [IDX_W-1:0] w_cand;

    // Scan farthest candidate first so the nearest one after i_last wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_found = 1'b1;
            end
        end
`ifdef MBC_ARB_PRIORITY_EN
        if (i_req[0]) begin
            o_idx   = '0;
            o_found = 1'b1;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/mbc_bus_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mbc_bus_arb - round-robin arbiter/sequencer for the shared mbc_out_ifc port
// with busy watchdog. Build option: MBC_ARB_PRIORITY_EN. Revision: 1.0
// ---------------------------------------------------------------------------
module mbc_bus_arb
    import mbc_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_WAIT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ*MBC_ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*MBC_DATA_W-1:0] req_write_data,
    output logic [NUM_REQ-1:0]            resp_done,
    output logic                          resp_error,
    output logic [MBC_DATA_W-1:0]         resp_read_data,
    output logic [MBC_ADDR_W-1:0]         mbc_out_ifc_address,
    output logic [MBC_DATA_W-1:0]         mbc_out_ifc_write_data,
    output logic                          mbc_out_ifc_write,
    output logic                          mbc_out_ifc_read,
    input  logic [MBC_DATA_W-1:0]         mbc_out_ifc_read_data,
    input  logic [31:0]                   mbc_out_ifc_control
);

    localparam int                 IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]         WD_LIMIT = 8'(MAX_WAIT);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    mbc_state_t             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_last;
    logic                   r_is_read;
    logic [7:0]             r_wd;
    logic [MBC_ADDR_W-1:0]  r_addr;
    logic [MBC_DATA_W-1:0]  r_wdata;
    logic [MBC_DATA_W-1:0]  r_rdata;
    logic                   r_wr_stb;
    logic                   r_rd_stb;
    logic                   r_err;
    logic [NUM_REQ-1:0]     r_done;

    logic [IDX_W-1:0]       w_win;
    logic                   w_found;
    logic                   w_win_wr;
    logic                   w_win_rd;
    logic [MBC_ADDR_W-1:0]  w_win_addr;
    logic [MBC_DATA_W-1:0]  w_win_wdata;
    logic                   w_busy;
    logic                   w_ctrl_unused;

    mbc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_idx   (w_win),
        .o_found (w_found)
    );

    assign w_win_wr      = req_write[w_win];
    assign w_win_rd      = req_read[w_win];
    assign w_win_addr    = req_address[MBC_ADDR_W*int'(w_win) +: MBC_ADDR_W];
    assign w_win_wdata   = req_write_data[MBC_DATA_W*int'(w_win) +: MBC_DATA_W];
    assign w_busy        = mbc_out_ifc_control[MBC_CTRL_BUSY_BIT];
    assign w_ctrl_unused = ^mbc_out_ifc_control;

    // Pulsed outputs default low every cycle; only a state transition raises them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_last    <= LAST_RST;
            r_is_read <= 1'b0;
            r_wd      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_wr_stb  <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= '0;
        end else begin
            r_wr_stb <= 1'b0;
            r_rd_stb <= 1'b0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_idx     <= w_win;
                        r_addr    <= w_win_addr;
                        r_wdata   <= w_win_wdata;
                        r_is_read <= w_win_rd;
                        if (mbc_req_legal(w_win_wr, w_win_rd)) begin
                            r_wr_stb <= w_win_wr;
                            r_rd_stb <= w_win_rd;
                            r_state  <= ST_ISSUE;
                        end else begin
                            r_done  <= ONE << w_win;
                            r_err   <= 1'b1;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!w_busy) begin
                        r_done  <= ONE << r_idx;
                        r_rdata <= r_is_read ? mbc_out_ifc_read_data : '0;
                        r_state <= ST_RESP;
                    end else if (r_wd == WD_LIMIT) begin
                        r_done  <= ONE << r_idx;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_last  <= r_idx;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign resp_done              = r_done;
    assign resp_error             = r_err;
    assign resp_read_data         = r_rdata;
    assign mbc_out_ifc_address    = r_addr;
    assign mbc_out_ifc_write_data = r_wdata;
    assign mbc_out_ifc_write      = r_wr_stb;
    assign mbc_out_ifc_read       = r_rd_stb;

endmodule
`default_nettype wire
